audiomap_sequencer: RTL and testbench

//  Sequences the ADPCM audio decoder through a two-buffer audiomap ring in sector memory.
//  The CPU marks buffers filled. On each 75 Hz audio_tick the sequencer starts the decoder
//    on the next filled buffer, then waits for completion.
//  On completion it frees the buffer and interrupts the CPU.

---
 rtl/audiomap_pkg.sv | 13 +
 rtl/audiomap_buffer_flags.sv | 21 ++
 rtl/audiomap_sequencer.sv | 147 ++++++++++++++
 tb/tb_audiomap_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/audiomap_pkg.sv
// audiomap_pkg: shared state encoding and default buffer addresses for the audiomap sequencer
package audiomap_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TICK,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_STOPPING
   } audiomap_state_e;
   localparam logic [12:0] BUF0_ADDR_DEF = 13'h0A00;
   localparam logic [12:0] BUF1_ADDR_DEF = 13'h0F00;
endpackage

// File: rtl/audiomap_buffer_flags.sv
// audiomap_buffer_flags: two per-buffer filled flags, a fill (set) beats a consume (clear) on the same buffer
// Ports: clk, reset (sync, active-high); set/set_idx mark a buffer filled;
//        clr/clr_idx mark a buffer consumed; valid[1:0] current flags.
module audiomap_buffer_flags (
   input  logic       clk,
   input  logic       reset,
   input  logic       set,
   input  logic       set_idx,
   input  logic       clr,
   input  logic       clr_idx,
   output logic [1:0] valid
);
   logic [1:0] valid_q, valid_d;
   always_comb begin
      for (int i = 0; i < 2; i++)
         valid_d[i] = (set && set_idx == 1'(i)) | (valid_q[i] & ~(clr && clr_idx == 1'(i)));
   end
   always_ff @(posedge clk)
      valid_q <= reset ? 2'b00 : valid_d;
   assign valid = valid_q;
endmodule

// File: rtl/audiomap_sequencer.sv
// audiomap_sequencer: steps the ADPCM decoder through a two-buffer audiomap ring on the 75 Hz tick
// Ports: clk, reset (sync, active-high)
//   cfg_start/cfg_stop       playback control pulses from CDIC registers
//   buf_fill/buf_fill_idx    CPU marks a buffer filled
//   audio_tick               75 Hz sector tick
//   dec_*                    decoder start/stop/address/filter-reset, idle and 0xFF-coding inputs
//   active, buf_valid, irq, irq_buf, irq_end, underrun   status to CPU
// Optional: AUDIOMAP_UNDERRUN_COUNT_EN adds underrun_count[7:0] (saturating, cleared on cfg_start).
module audiomap_sequencer
   import audiomap_pkg::*;
#(
   parameter logic [12:0] BUF0_ADDR  = BUF0_ADDR_DEF,
   parameter logic [12:0] BUF1_ADDR  = BUF1_ADDR_DEF,
   parameter bit          RESET_FILT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic        buf_fill,
   input  logic        buf_fill_idx,
   input  logic        audio_tick,
   output logic        dec_start_playback,
   output logic [12:0] dec_playback_addr,
   output logic        dec_reset_filter,
   output logic        dec_stop_playback,
   input  logic        dec_idle,
   input  logic        dec_disable_audiomap,
   output logic        active,
   output logic [1:0]  buf_valid,
   output logic        irq,
   output logic        irq_buf,
   output logic        irq_end,
   output logic        underrun
`ifdef AUDIOMAP_UNDERRUN_COUNT_EN
   ,
   output logic [7:0]  underrun_count
`endif
);
   audiomap_state_e state_q, state_d;
   logic cur_q, cur_d, first_q, first_d, underrun_q, underrun_d;
   logic irq_q, irq_d, irq_buf_q, irq_buf_d, irq_end_q, irq_end_d, stop_q, stop_d;
   logic clr, start_acc, ur_ev;
   assign start_acc = state_q == ST_IDLE && cfg_start && !cfg_stop;
   assign ur_ev = state_q == ST_WAIT_TICK && !cfg_stop && audio_tick && !buf_valid[cur_q];
   audiomap_buffer_flags u_flags (
      .clk     (clk),
      .reset   (reset),
      .set     (buf_fill),
      .set_idx (buf_fill_idx),
      .clr     (clr),
      .clr_idx (cur_q),
      .valid   (buf_valid)
   );
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      first_d    = first_q;
      underrun_d = underrun_q;
      irq_d      = 1'b0;
      irq_buf_d  = irq_buf_q;
      irq_end_d  = irq_end_q;
      stop_d     = 1'b0;
      clr        = 1'b0;
      case (state_q)
         ST_IDLE: if (start_acc) begin
            state_d    = ST_WAIT_TICK;
            cur_d      = 1'b0;
            first_d    = 1'b1;
            underrun_d = 1'b0;
         end
         ST_WAIT_TICK: begin
            if (cfg_stop) state_d = ST_IDLE;
            else if (ur_ev) begin
               underrun_d = 1'b1;
               first_d    = 1'b1;
            end else if (audio_tick && dec_idle) state_d = ST_START;
         end
         ST_START: begin
            state_d = cfg_stop ? ST_IDLE : ST_WAIT_BUSY;
            first_d = cfg_stop & first_q;
         end
         ST_WAIT_BUSY, ST_WAIT_DONE: begin
            if (cfg_stop) begin
               stop_d  = 1'b1;
               state_d = ST_STOPPING;
            end else if (dec_disable_audiomap) begin
               clr       = 1'b1;
               irq_d     = 1'b1;
               irq_end_d = 1'b1;
               irq_buf_d = cur_q;
               state_d   = ST_IDLE;
            end else if (state_q == ST_WAIT_BUSY) begin
               // decoder still reports idle for one cycle after the start pulse
               if (!dec_idle) state_d = ST_WAIT_DONE;
            end else if (dec_idle) begin
               clr       = 1'b1;
               irq_d     = 1'b1;
               irq_end_d = 1'b0;
               irq_buf_d = cur_q;
               cur_d     = ~cur_q;
               state_d   = ST_WAIT_TICK;
            end
         end
         ST_STOPPING: if (dec_idle) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cur_q      <= 1'b0;
         first_q    <= 1'b1;
         underrun_q <= 1'b0;
         irq_q      <= 1'b0;
         irq_buf_q  <= 1'b0;
         irq_end_q  <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         first_q    <= first_d;
         underrun_q <= underrun_d;
         irq_q      <= irq_d;
         irq_buf_q  <= irq_buf_d;
         irq_end_q  <= irq_end_d;
         stop_q     <= stop_d;
      end
   end
`ifdef AUDIOMAP_UNDERRUN_COUNT_EN
   logic [7:0] ucnt_q, ucnt_d;
   assign ucnt_d = start_acc ? 8'd0 : (ur_ev && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
   always_ff @(posedge clk)
      ucnt_q <= reset ? 8'd0 : ucnt_d;
   assign underrun_count = ucnt_q;
`endif
   // a stop arriving in START cancels the pulse before the decoder sees it
   assign dec_start_playback = state_q == ST_START && !cfg_stop;
   assign dec_playback_addr  = dec_start_playback ? (cur_q ? BUF1_ADDR : BUF0_ADDR) : 13'd0;
   assign dec_reset_filter   = dec_start_playback & first_q & RESET_FILT;
   assign dec_stop_playback  = stop_q;
   assign active             = state_q != ST_IDLE;
   assign irq                = irq_q;
   assign irq_buf            = irq_buf_q;
   assign irq_end            = irq_end_q;
   assign underrun           = underrun_q;
endmodule

// File: tb/tb_audiomap_sequencer.sv
// tb_audiomap_sequencer: directed checks of the audiomap sequencer against a simple busy-counter decoder model
module tb_audiomap_sequencer;
   logic clk = 1'b0, reset = 1'b1, cfg_start = 1'b0, cfg_stop = 1'b0;
   logic buf_fill = 1'b0, buf_fill_idx = 1'b0, audio_tick = 1'b0, dec_disable_audiomap = 1'b0;
   logic dec_start_playback, dec_reset_filter, dec_stop_playback, dec_idle;
   logic [12:0] dec_playback_addr;
   logic active, irq, irq_buf, irq_end, underrun;
   logic [1:0] buf_valid;
`ifdef AUDIOMAP_UNDERRUN_COUNT_EN
   logic [7:0] underrun_count;
`endif
   int nvec = 0, nerr = 0, busy_len = 100, n;
   bit model_en = 1'b1, irq_seen;
   logic [7:0] cnt;
   audiomap_sequencer dut (
      .clk                  (clk),
      .reset                (reset),
      .cfg_start            (cfg_start),
      .cfg_stop             (cfg_stop),
      .buf_fill             (buf_fill),
      .buf_fill_idx         (buf_fill_idx),
      .audio_tick           (audio_tick),
      .dec_start_playback   (dec_start_playback),
      .dec_playback_addr    (dec_playback_addr),
      .dec_reset_filter     (dec_reset_filter),
      .dec_stop_playback    (dec_stop_playback),
      .dec_idle             (dec_idle),
      .dec_disable_audiomap (dec_disable_audiomap),
      .active               (active),
      .buf_valid            (buf_valid),
      .irq                  (irq),
      .irq_buf              (irq_buf),
      .irq_end              (irq_end),
      .underrun             (underrun)
`ifdef AUDIOMAP_UNDERRUN_COUNT_EN
      ,
      .underrun_count       (underrun_count)
`endif
   );
   always #5 clk = ~clk;
   // decoder model: busy for busy_len cycles after a start, a few cycles to wind down after a stop
   always @(posedge clk) begin
      if (reset) cnt <= 8'd0;
      else if (dec_stop_playback) cnt <= 8'd3;
      else if (dec_start_playback && model_en) cnt <= 8'(busy_len);
      else if (cnt != 8'd0) cnt <= cnt - 8'd1;
   end
   assign dec_idle = cnt == 8'd0;
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic pulse_fill(input logic idx);
      buf_fill = 1'b1;
      buf_fill_idx = idx;
      cyc;
      buf_fill = 1'b0;
   endtask
   task automatic pulse_tick;
      audio_tick = 1'b1;
      cyc;
      audio_tick = 1'b0;
   endtask
   task automatic pulse_start;
      cfg_start = 1'b1;
      cyc;
      cfg_start = 1'b0;
   endtask
   task automatic pulse_stop;
      cfg_stop = 1'b1;
      cyc;
      cfg_stop = 1'b0;
   endtask
   task automatic wait_irq(output int cycles);
      cycles = 0;
      for (int i = 0; i < 400 && !irq; i++) begin
         cyc;
         cycles++;
      end
      chk("irq_wait", irq, 1);
   endtask
   initial begin
      cyc;
      cyc;
      reset = 1'b0;
      chk("rst_active", active, 0);
      chk("rst_valid", buf_valid, 0);
      chk("rst_irq", irq, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_start", dec_start_playback, 0);
      chk("rst_addr", dec_playback_addr, 0);
`ifdef AUDIOMAP_UNDERRUN_COUNT_EN
      chk("rst_ucount", underrun_count, 0);
`endif
      // single buffer playback
      pulse_fill(1'b0);
      chk("fill0_valid", buf_valid, 2'b01);
      pulse_start;
      chk("start_active", active, 1);
      pulse_tick;
      chk("t1_start", dec_start_playback, 1);
      chk("t1_addr", dec_playback_addr, 13'h0A00);
      chk("t1_rf", dec_reset_filter, 1);
      cyc;
      chk("t1_start_pulse", dec_start_playback, 0);
      wait_irq(n);
      chk("t1_latency", n, 101);
      chk("t1_irq_buf", irq_buf, 0);
      chk("t1_irq_end", irq_end, 0);
      chk("t1_valid", buf_valid, 2'b00);
      chk("t1_active", active, 1);
      cyc;
      chk("t1_irq_pulse", irq, 0);
      // ring through both buffers, then underrun and recovery
      pulse_stop;
      chk("stop_wt_active", active, 0);
      pulse_fill(1'b0);
      pulse_fill(1'b1);
      chk("fill01_valid", buf_valid, 2'b11);
      pulse_start;
      pulse_tick;
      chk("t2_addr", dec_playback_addr, 13'h0A00);
      chk("t2_rf", dec_reset_filter, 1);
      wait_irq(n);
      chk("t2_irq_buf", irq_buf, 0);
      pulse_tick;
      chk("t3_start", dec_start_playback, 1);
      chk("t3_addr", dec_playback_addr, 13'h0F00);
      chk("t3_rf", dec_reset_filter, 0);
      wait_irq(n);
      chk("t3_irq_buf", irq_buf, 1);
      chk("t3_valid", buf_valid, 2'b00);
      pulse_tick;
      chk("ur_flag", underrun, 1);
      chk("ur_start", dec_start_playback, 0);
      chk("ur_active", active, 1);
      pulse_fill(1'b0);
      pulse_tick;
      chk("ur_rec_addr", dec_playback_addr, 13'h0A00);
      chk("ur_rec_rf", dec_reset_filter, 1);
      wait_irq(n);
      // 0xFF coding terminates the audiomap
      pulse_stop;
      pulse_fill(1'b0);
      pulse_start;
      chk("restart_ur_clr", underrun, 0);
      model_en = 1'b0;
      pulse_tick;
      chk("ff_start", dec_start_playback, 1);
      cyc;
      dec_disable_audiomap = 1'b1;
      cyc;
      dec_disable_audiomap = 1'b0;
      chk("ff_irq", irq, 1);
      chk("ff_irq_end", irq_end, 1);
      chk("ff_irq_buf", irq_buf, 0);
      chk("ff_active", active, 0);
      chk("ff_valid", buf_valid, 2'b00);
      pulse_fill(1'b0);
      pulse_tick;
      chk("ff_no_start", dec_start_playback, 0);
      chk("ff_still_idle", active, 0);
      model_en = 1'b1;
      // stop while the decoder is busy
      pulse_start;
      pulse_tick;
      cyc;
      cyc;
      cyc;
      cyc;
      pulse_stop;
      chk("stop_pulse", dec_stop_playback, 1);
      chk("stop_active", active, 1);
      cyc;
      chk("stop_pulse_end", dec_stop_playback, 0);
      irq_seen = 1'b0;
      for (int i = 0; i < 50 && active; i++) begin
         cyc;
         irq_seen |= irq;
      end
      chk("stop_done", active, 0);
      chk("stop_no_irq", irq_seen, 0);
      chk("stop_valid", buf_valid, 2'b01);
      // refill of the buffer on the very cycle it is consumed
      busy_len = 5;
      pulse_start;
      pulse_tick;
      chk("fw_addr", dec_playback_addr, 13'h0A00);
      cyc;
      for (int i = 0; i < 20 && !dec_idle; i++) cyc;
      pulse_fill(1'b0);
      chk("fw_irq", irq, 1);
      chk("fw_valid", buf_valid, 2'b01);
      // reset during WAIT_DONE
      busy_len = 100;
      pulse_fill(1'b1);
      pulse_tick;
      chk("rs_addr", dec_playback_addr, 13'h0F00);
      chk("rs_rf", dec_reset_filter, 0);
      cyc;
      cyc;
      reset = 1'b1;
      cyc;
      chk("rs_active", active, 0);
      chk("rs_valid", buf_valid, 0);
      chk("rs_irq_buf", irq_buf, 0);
      chk("rs_irq_end", irq_end, 0);
      chk("rs_stop", dec_stop_playback, 0);
      chk("rs_start", dec_start_playback, 0);
      reset = 1'b0;
      cyc;
`ifdef AUDIOMAP_UNDERRUN_COUNT_EN
      pulse_start;
      for (int i = 0; i < 300; i++) begin
         pulse_tick;
         cyc;
      end
      chk("uc_sat", underrun_count, 255);
      chk("uc_flag", underrun, 1);
      pulse_stop;
      pulse_start;
      chk("uc_clr", underrun_count, 0);
      chk("uc_flag_clr", underrun, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
